wide_alu_sched: RTL and testbench
=================================

Name: wide_alu_sched

Overview:
Multi-requester scheduler that shares one wide_alu instance between NUM_REQ clients.
- Round-robin arbitration selects one job at a time.
- For each job it programs op_sel, pulses trigger, and tracks the ALU busy/error status until completion.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between the bus-facing front ends and the wide_alu datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OP_WIDTH, 256, width of each operand
RES_WIDTH, 512, width of the ALU result
OPSEL_WIDTH, 3, width of the operation selector
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT_DONE (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  NUM_REQ  per-requester job valid
req_ready_o  out  NUM_REQ  one-hot job accept
req_op_a_i  in  NUM_REQ*OP_WIDTH  operand A, requester i in slice i
req_op_b_i  in  NUM_REQ*OP_WIDTH  operand B, flattened the same way
req_op_sel_i  in  NUM_REQ*OPSEL_WIDTH  operation, flattened the same way
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  $clog2(NUM_REQ)  requester index of the response
rsp_result_o  out  RES_WIDTH  captured result
rsp_err_o  out  1  ALU error (or timeout) flag
alu_op_a_o  out  OP_WIDTH  to wide_alu op_a_i
alu_op_b_o  out  OP_WIDTH  to wide_alu op_b_i
alu_op_sel_o  out  OPSEL_WIDTH  to wide_alu op_sel_i
alu_op_sel_we_o  out  1  op_sel write strobe
alu_trigger_o  out  1  start pulse
alu_clear_err_o  out  1  error-clear pulse
alu_busy_i  in  1  ALU busy, from status_o
alu_err_i  in  1  ALU error, from status_o
alu_result_i  in  RES_WIDTH  ALU result

Behaviour:
- Reset values:
  - All outputs are 0, FSM is IDLE, RR pointer is 0.
  - Operand, result and ID registers are 0.
- Arbitration, in IDLE:
  - The first requester with req_valid_i set is granted, searching from the RR pointer upward with wrap.
  - req_ready_o[g] is high for exactly that cycle; the handshake happens in the same cycle.
  - Operands, op_sel and ID are latched into alu_* registers.
  - The RR pointer becomes (g+1) mod NUM_REQ.
  - The FSM moves to CFG.
  - No grant is given outside IDLE, and at most one ready bit is ever high.
- CFG: alu_op_sel_we_o=1 for one cycle, then TRIG.
- TRIG: alu_trigger_o=1 for one cycle, then WAIT_START.
- WAIT_START:
  - If alu_busy_i=1, go to WAIT_DONE.
  - If busy is not seen within 2 cycles, the job counts as complete immediately: capture and go to RESP.
- WAIT_DONE:
  - On alu_busy_i=0, capture alu_result_i into rsp_result_o and alu_err_i into rsp_err_o, then go to RESP.
- RESP:
  - rsp_valid_o=1 and all response fields are held stable until rsp_ready_i.
  - On the handshake, go to CLR_ERR if rsp_err_o=1, else IDLE.
- CLR_ERR: alu_clear_err_o=1 for one cycle, then IDLE.
- Latency:
  - Request accept to trigger is 2 cycles.
  - ALU completion (busy falls) to rsp_valid_o is 1 cycle.
  - The earliest next grant is the cycle after the response handshake.
- alu_op_a/b/sel_o stay stable from grant until the next grant.
- Boundary conditions:
  - A requester that drops req_valid_i before grant is simply skipped; no state changes.
  - With NUM_REQ requesters continuously valid, each is served once per NUM_REQ jobs; starvation is impossible.
  - alu_err_i outside WAIT_DONE/WAIT_START capture is ignored.
  - Reset mid-operation aborts the job: no response is issued and no clear pulse is generated. The ALU is reset by the same rst_ni.
  - rsp_ready_i held high permanently gives a 1-cycle RESP.

Optional Feature:
- Macro: WIDE_ALU_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entering WAIT_DONE and increments each cycle there.
  - When the count reaches TIMEOUT_CYCLES with busy still high: capture result = 0, rsp_err_o=1, go to RESP. CLR_ERR then follows.
- When undefined: no counter, and WAIT_DONE waits indefinitely.

Test Plan:
- Single job: req 2 with A=5, B=7, sel=0. Expect ready[2] in the same cycle, op_sel_we 1 cycle later, trigger 2 cycles after accept, and the response with id=2 carrying the ALU result, err=0.
- Fairness: all 4 valid continuously, 8 jobs. Grant order is 0,1,2,3,0,1,2,3, with at most one ready bit per cycle.
- Backpressure: rsp_ready_i=0 for 10 cycles. rsp_valid_o, id and result hold; no new grant until the handshake.
- Error path: model asserts alu_err_i when busy falls. Expect rsp_err_o=1, then alu_clear_err_o for exactly 1 cycle after the handshake, then IDLE.
- Reset mid-job: assert rst_ni low in WAIT_DONE. All outputs are 0, no response; after release the next grant starts from requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): busy stuck at 1. Expect the response 16 cycles after entering WAIT_DONE with err=1 and result 0.

Source files
------------

// File: rtl/wide_alu_sched.sv
// Round-robin scheduler sharing one wide_alu between NUM_REQ requesters.
// Define WIDE_ALU_SCHED_TIMEOUT_EN to add a WAIT_DONE watchdog of TIMEOUT_CYCLES.
module wide_alu_sched #(
    parameter int NUM_REQ        = 4,
    parameter int OP_WIDTH       = 256,
    parameter int RES_WIDTH      = 512,
    parameter int OPSEL_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_a_i,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_b_i,
    input  logic [NUM_REQ*OPSEL_WIDTH-1:0] req_op_sel_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id_o,
    output logic [RES_WIDTH-1:0]           rsp_result_o,
    output logic                           rsp_err_o,
    output logic [OP_WIDTH-1:0]            alu_op_a_o,
    output logic [OP_WIDTH-1:0]            alu_op_b_o,
    output logic [OPSEL_WIDTH-1:0]         alu_op_sel_o,
    output logic                           alu_op_sel_we_o,
    output logic                           alu_trigger_o,
    output logic                           alu_clear_err_o,
    input  logic                           alu_busy_i,
    input  logic                           alu_err_i,
    input  logic [RES_WIDTH-1:0]           alu_result_i
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE, CFG, TRIG, WAIT_START, WAIT_DONE, RESP, CLR_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [IDW-1:0]         rr_q, rr_d, id_q, id_d;
    logic [OP_WIDTH-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [OPSEL_WIDTH-1:0] op_sel_q, op_sel_d;
    logic [RES_WIDTH-1:0]   result_q, result_d;
    logic                   err_q, err_d, valid_q, valid_d;
    logic                   we_q, we_d, trig_q, trig_d, clr_q, clr_d;
    logic                   start_cnt_q, start_cnt_d;
`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
    logic [15:0]            to_cnt_q, to_cnt_d;
`endif

    logic [OP_WIDTH-1:0]    op_a_arr   [NUM_REQ];
    logic [OP_WIDTH-1:0]    op_b_arr   [NUM_REQ];
    logic [OPSEL_WIDTH-1:0] op_sel_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_a_arr[gi]   = req_op_a_i[gi*OP_WIDTH +: OP_WIDTH];
        assign op_b_arr[gi]   = req_op_b_i[gi*OP_WIDTH +: OP_WIDTH];
        assign op_sel_arr[gi] = req_op_sel_i[gi*OPSEL_WIDTH +: OPSEL_WIDTH];
    end

    // Scan offsets from high to low so the requester closest to rr_q wins.
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand;
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
            if (req_valid_i[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // The accept handshake must complete in the grant cycle, so ready is decoded combinationally.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready_o[gi] = rst_ni && (state_q == IDLE) && grant_found
                                 && (grant_idx == IDW'(gi));
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        result_d    = result_q;
        err_d       = err_q;
        valid_d     = valid_q;
        we_d        = 1'b0;
        trig_d      = 1'b0;
        clr_d       = 1'b0;
        start_cnt_d = start_cnt_q;
`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    id_d     = grant_idx;
                    op_a_d   = op_a_arr[grant_idx];
                    op_b_d   = op_b_arr[grant_idx];
                    op_sel_d = op_sel_arr[grant_idx];
                    rr_d     = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    we_d     = 1'b1;
                    state_d  = CFG;
                end
            end
            CFG: begin
                trig_d  = 1'b1;
                state_d = TRIG;
            end
            TRIG: begin
                start_cnt_d = 1'b0;
                state_d     = WAIT_START;
            end
            WAIT_START: begin
                if (alu_busy_i) begin
`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    state_d  = WAIT_DONE;
                end else if (start_cnt_q) begin
                    // Busy never showed up: treat the job as already finished.
                    result_d = alu_result_i;
                    err_d    = alu_err_i;
                    valid_d  = 1'b1;
                    state_d  = RESP;
                end else begin
                    start_cnt_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!alu_busy_i) begin
                    result_d = alu_result_i;
                    err_d    = alu_err_i;
                    valid_d  = 1'b1;
                    state_d  = RESP;
                end
`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
                else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    valid_d = 1'b0;
                    if (err_q) begin
                        clr_d   = 1'b1;
                        state_d = CLR_ERR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CLR_ERR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            trig_q      <= 1'b0;
            clr_q       <= 1'b0;
            start_cnt_q <= 1'b0;
`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            result_q    <= result_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            we_q        <= we_d;
            trig_q      <= trig_d;
            clr_q       <= clr_d;
            start_cnt_q <= start_cnt_d;
`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign rsp_valid_o     = valid_q;
    assign rsp_id_o        = id_q;
    assign rsp_result_o    = result_q;
    assign rsp_err_o       = err_q;
    assign alu_op_a_o      = op_a_q;
    assign alu_op_b_o      = op_b_q;
    assign alu_op_sel_o    = op_sel_q;
    assign alu_op_sel_we_o = we_q;
    assign alu_trigger_o   = trig_q;
    assign alu_clear_err_o = clr_q;

endmodule

// File: tb/tb_wide_alu_sched.sv
// Scoreboard bench for wide_alu_sched: random requesters, behavioural ALU, decoupled monitor.
module tb_wide_alu_sched;
    localparam int N    = 4;
    localparam int OPW  = 256;
    localparam int RESW = 512;
    localparam int SW   = 3;
    localparam int TO   = 16;
    localparam int IDW  = 2;
`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [N*OPW-1:0]  req_op_a_i = '0;
    logic [N*OPW-1:0]  req_op_b_i = '0;
    logic [N*SW-1:0]   req_op_sel_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [IDW-1:0]    rsp_id_o;
    logic [RESW-1:0]   rsp_result_o;
    logic              rsp_err_o;
    logic [OPW-1:0]    alu_op_a_o, alu_op_b_o;
    logic [SW-1:0]     alu_op_sel_o;
    logic              alu_op_sel_we_o, alu_trigger_o, alu_clear_err_o;
    logic              m_busy, m_err;
    logic [RESW-1:0]   m_res;

    always #5 clk = ~clk;

    wide_alu_sched #(
        .NUM_REQ(N), .OP_WIDTH(OPW), .RES_WIDTH(RESW),
        .OPSEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_op_sel_i(req_op_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
        .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o), .alu_op_sel_o(alu_op_sel_o),
        .alu_op_sel_we_o(alu_op_sel_we_o), .alu_trigger_o(alu_trigger_o),
        .alu_clear_err_o(alu_clear_err_o),
        .alu_busy_i(m_busy), .alu_err_i(m_err), .alu_result_i(m_res)
    );

    typedef struct {
        int              id;
        logic [RESW-1:0] res;
        logic            err;
        int              exp_cyc;
    } exp_t;
    typedef struct {
        int   lat;
        logic err;
    } job_t;

    exp_t sb_q[$];
    job_t alu_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic job_open = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RESW-1:0] ref_alu(logic [OPW-1:0] a, logic [OPW-1:0] b,
                                                logic [SW-1:0] s);
        logic [RESW-1:0] wa, wb;
        wa = RESW'(a);
        wb = RESW'(b);
        case (s)
            3'd0:    return wa + wb;
            3'd1:    return wa - wb;
            3'd2:    return wa * wb;
            3'd3:    return {a, b};
            3'd4:    return wa & wb;
            3'd5:    return wa | wb;
            default: return wa ^ wb;
        endcase
    endfunction

    function automatic logic [OPW-1:0] rand_op();
        logic [OPW-1:0] v;
        for (int k = 0; k < OPW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural ALU: result ready at trigger, busy for lat cycles, error raised when busy falls.
    initial begin
        job_t j;
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_res  = '0;
        forever begin
            int cnt;
            logic eflag;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy <= 1'b0;
                m_err  <= 1'b0;
                m_res  <= '0;
                cnt    = 0;
            end else begin
                if (alu_clear_err_o) m_err <= 1'b0;
                if (alu_trigger_o) begin
                    j.lat = 1;
                    j.err = 1'b0;
                    if (alu_q.size() > 0) j = alu_q.pop_front();
                    m_res <= ref_alu(alu_op_a_o, alu_op_b_o, alu_op_sel_o);
                    eflag = j.err;
                    cnt   = j.lat;
                    if (j.lat == 0) begin
                        m_busy <= 1'b0;
                        m_err  <= j.err;
                    end else begin
                        m_busy <= 1'b1;
                    end
                end else if (m_busy) begin
                    if (cnt == 1) begin
                        m_busy <= 1'b0;
                        m_err  <= eflag;
                    end
                    cnt = cnt - 1;
                end
            end
        end
    end

    // Monitor: reference arbiter, strobe timing, response scoreboard.
    initial begin
        int   ref_rr, pick, c, acc_cyc, clr_cyc, stall;
        logic prev_valid, have_cur, exp_we, exp_trig, exp_clr;
        logic [N-1:0]   exp_ready;
        logic [OPW-1:0] ra, rb;
        logic [SW-1:0]  rs;
        exp_t cur;
        ref_rr = 0; acc_cyc = -100; clr_cyc = -100; stall = 0;
        prev_valid = 1'b0; have_cur = 1'b0;
        ra = '0; rb = '0; rs = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                checks++;
                if (req_ready_o != '0 || rsp_valid_o || rsp_id_o != '0 || rsp_result_o != '0
                    || rsp_err_o || alu_op_a_o != '0 || alu_op_b_o != '0 || alu_op_sel_o != '0
                    || alu_op_sel_we_o || alu_trigger_o || alu_clear_err_o) begin
                    failures++;
                    $display("FAIL reset_outputs: got ready=%h valid=%b id=%0d err=%b we=%b trig=%b clr=%b res_nz=%b ops_nz=%b, required all zero",
                             req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, alu_op_sel_we_o,
                             alu_trigger_o, alu_clear_err_o, |rsp_result_o,
                             (|alu_op_a_o) | (|alu_op_b_o) | (|alu_op_sel_o));
                end
                ref_rr = 0; job_open = 1'b0; prev_valid = 1'b0; have_cur = 1'b0;
                clr_cyc = -100; acc_cyc = -100; stall = 0;
            end else begin
                exp_ready = '0;
                pick = -1;
                if (!job_open) begin
                    for (int k = 0; k < N; k++) begin
                        c = (ref_rr + k) % N;
                        if (req_valid_i[c] && pick < 0) pick = c;
                    end
                    if (pick >= 0) exp_ready[pick] = 1'b1;
                end
                if (exp_ready != '0 || req_ready_o != '0) begin
                    checks++;
                    if (req_ready_o != exp_ready) begin
                        failures++;
                        $display("FAIL grant: cycle %0d ready=%b required %b (valid=%b)",
                                 cyc, req_ready_o, exp_ready, req_valid_i);
                    end
                end
                if (pick >= 0) begin
                    job_open = 1'b1;
                    acc_cyc  = cyc;
                    ref_rr   = (pick + 1) % N;
                    ra = req_op_a_i[pick*OPW +: OPW];
                    rb = req_op_b_i[pick*OPW +: OPW];
                    rs = req_op_sel_i[pick*SW +: SW];
                    stall = 0;
                end

                exp_we   = (cyc == acc_cyc + 1);
                exp_trig = (cyc == acc_cyc + 2);
                exp_clr  = (cyc == clr_cyc);
                if (exp_we || alu_op_sel_we_o) begin
                    checks++;
                    if (alu_op_sel_we_o != exp_we) begin
                        failures++;
                        $display("FAIL op_sel_we: cycle %0d got %b required %b", cyc, alu_op_sel_we_o, exp_we);
                    end
                end
                if (exp_trig || alu_trigger_o) begin
                    checks++;
                    if (alu_trigger_o != exp_trig) begin
                        failures++;
                        $display("FAIL trigger: cycle %0d got %b required %b", cyc, alu_trigger_o, exp_trig);
                    end
                end
                if (exp_trig) begin
                    checks++;
                    if (alu_op_a_o != ra || alu_op_b_o != rb || alu_op_sel_o != rs) begin
                        failures++;
                        $display("FAIL alu_operands: got sel=%0d a=%h required sel=%0d a=%h",
                                 alu_op_sel_o, alu_op_a_o, rs, ra);
                    end
                end
                if (exp_clr || alu_clear_err_o) begin
                    checks++;
                    if (alu_clear_err_o != exp_clr) begin
                        failures++;
                        $display("FAIL clear_err: cycle %0d got %b required %b", cyc, alu_clear_err_o, exp_clr);
                    end
                end
                if (exp_clr) job_open = 1'b0;

                if (rsp_valid_o) begin
                    if (!prev_valid) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            failures++;
                            have_cur = 1'b0;
                            $display("FAIL rsp_unexpected: cycle %0d got response id=%0d, required none", cyc, rsp_id_o);
                        end else begin
                            cur = sb_q.pop_front();
                            have_cur = 1'b1;
                            if (cyc != cur.exp_cyc) begin
                                failures++;
                                $display("FAIL rsp_latency: id=%0d valid at cycle %0d required %0d", cur.id, cyc, cur.exp_cyc);
                            end
                        end
                    end
                    if (have_cur) begin
                        checks++;
                        if (rsp_id_o != IDW'(cur.id) || rsp_result_o != cur.res || rsp_err_o != cur.err) begin
                            failures++;
                            $display("FAIL rsp_fields: got id=%0d err=%b res=%h required id=%0d err=%b res=%h",
                                     rsp_id_o, rsp_err_o, rsp_result_o, cur.id, cur.err, cur.res);
                        end
                    end
                    if (rsp_ready_i) begin
                        $display("rsp cycle=%0d id=%0d err=%b res=%h", cyc, rsp_id_o, rsp_err_o, rsp_result_o[63:0]);
                        if (rsp_err_o) clr_cyc = cyc + 1;
                        else job_open = 1'b0;
                        have_cur = 1'b0;
                        stall = 0;
                    end
                end
                prev_valid = rsp_valid_o && !rsp_ready_i;

                if (job_open) begin
                    stall++;
                    if (stall > 300) begin
                        checks++;
                        failures++;
                        $display("FAIL job_stall: no response within 300 cycles, required a response");
                        stall = 0;
                        job_open = 1'b0;
                    end
                end
            end
        end
    end

    // Driver state
    logic [OPW-1:0] ja [N];
    logic [OPW-1:0] jb [N];
    logic [SW-1:0]  js [N];
    logic           pend [N];
    int  gen_prob = 0, drop_en = 0, rdy_mode = 0, fixed_lat = 1, fixed_err = 0, n_acc = 0;
    logic man_rdy = 1'b0;

    task automatic new_job(int i);
        ja[i] = rand_op();
        jb[i] = rand_op();
        js[i] = SW'($urandom_range(0, 7));
        pend[i] = 1'b1;
    endtask

    task automatic accept(int i);
        exp_t e;
        job_t j;
        j.lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 5);
        j.err = (fixed_err >= 0) ? fixed_err[0] : ($urandom_range(0, 3) == 0);
        e.id = i;
        if (TO_EN && j.lat >= TO + 1) begin
            e.res = '0;
            e.err = 1'b1;
            e.exp_cyc = cyc + 4 + TO;
        end else begin
            e.res = ref_alu(ja[i], jb[i], js[i]);
            e.err = j.err;
            e.exp_cyc = cyc + ((j.lat == 0) ? 5 : 4 + j.lat);
        end
        sb_q.push_back(e);
        alu_q.push_back(j);
        n_acc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && gen_prob > 0 && $urandom_range(0, 99) < gen_prob) new_job(i);
            else if (pend[i] && drop_en != 0 && $urandom_range(0, 99) < 3) pend[i] = 1'b0;
            req_valid_i[i] = pend[i];
            req_op_a_i[i*OPW +: OPW] = ja[i];
            req_op_b_i[i*OPW +: OPW] = jb[i];
            req_op_sel_i[i*SW +: SW] = js[i];
        end
        rsp_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : man_rdy;
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid_i[i] && req_ready_o[i]) begin
                accept(i);
                pend[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_accepts(int k);
        int target;
        target = n_acc + k;
        for (int c = 0; c < 3000 && n_acc < target; c++) cycle();
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 600 && (sb_q.size() != 0 || job_open); c++) cycle();
        cycle();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ja[i] = '0; jb[i] = '0; js[i] = '0; pend[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed single job on requester 2: 5 + 7.
        ja[2] = OPW'(5); jb[2] = OPW'(7); js[2] = '0; pend[2] = 1'b1;
        fixed_lat = 3; fixed_err = 0;
        wait_accepts(1);
        drain();

        // Fairness: all requesters continuously valid for 8 jobs.
        gen_prob = 100; fixed_lat = 1;
        for (int i = 0; i < N; i++) new_job(i);
        wait_accepts(8);
        gen_prob = 0; clear_pend();
        drain();

        // Random traffic with drops, random latency/errors and random backpressure.
        gen_prob = 30; drop_en = 1; rdy_mode = 1; fixed_lat = -1; fixed_err = -1;
        wait_accepts(60);
        gen_prob = 0; drop_en = 0; clear_pend();
        drain();

        // Backpressure: hold rsp_ready low 10 cycles while others keep requesting.
        rdy_mode = 2; man_rdy = 1'b0; fixed_lat = 2; fixed_err = 0;
        for (int i = 0; i < N; i++) new_job(i);
        wait_accepts(1);
        for (int c = 0; c < 50 && !rsp_valid_o; c++) cycle();
        repeat (10) cycle();
        man_rdy = 1'b1;
        cycle();
        clear_pend(); rdy_mode = 0;
        drain();

        // Error path with clear pulse.
        fixed_lat = 2; fixed_err = 1;
        new_job(0);
        wait_accepts(1);
        drain();

        // Reset in WAIT_DONE aborts the job; arbitration restarts at requester 0.
        fixed_lat = 40; fixed_err = 0;
        new_job(3);
        wait_accepts(1);
        repeat (8) cycle();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid_i = '0;
        clear_pend();
        sb_q.delete();
        alu_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fixed_lat = 1;
        for (int i = 0; i < N; i++) new_job(i);
        wait_accepts(4);
        clear_pend();
        drain();

        if (TO_EN) begin
            fixed_lat = 200; fixed_err = 0;
            new_job(2);
            wait_accepts(1);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule
